// File: rtl/german_pkg.sv
// german_pkg: shared types for the German coherence model.
// Holds cache/command enums, message and cache records, the full state
// record exported for observation, rule-kind codes and the reset value.
package german_pkg;

  localparam int NUM_NODES = 3;
  localparam int NODE_W    = 2;
  localparam int DATA_W    = 2;
  localparam int SEL_W     = 5;

  typedef logic [NODE_W-1:0] node_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    CACHE_I = 2'd0,
    CACHE_S = 2'd1,
    CACHE_E = 2'd2
  } cache_state_e;

  typedef enum logic [2:0] {
    CMD_EMPTY  = 3'd0,
    CMD_REQS   = 3'd1,
    CMD_REQE   = 3'd2,
    CMD_INV    = 3'd3,
    CMD_INVACK = 3'd4,
    CMD_GNTS   = 3'd5,
    CMD_GNTE   = 3'd6
  } cmd_e;

  typedef struct packed {
    cmd_e  cmd;
    data_t data;
  } msg_t;

  typedef struct packed {
    cache_state_e state;
    data_t        data;
  } cache_t;

  // Complete protocol state; one register of this type is the whole model.
  typedef struct packed {
    cache_t [NUM_NODES-1:0] cache;
    msg_t   [NUM_NODES-1:0] chan1;
    msg_t   [NUM_NODES-1:0] chan2;
    msg_t   [NUM_NODES-1:0] chan3;
    logic   [NUM_NODES-1:0] inv_set;
    logic   [NUM_NODES-1:0] shr_set;
    logic                   ex_gntd;
    cmd_e                   cur_cmd;
    node_t                  cur_ptr;
    data_t                  mem_data;
    data_t                  aux_data;
  } german_state_t;

  // Rule kinds carried in io_en_a[4:2].
  localparam logic [2:0] K_RECV_GNT    = 3'd0;
  localparam logic [2:0] K_SEND_REQS   = 3'd1;
  localparam logic [2:0] K_SEND_REQE   = 3'd2;
  localparam logic [2:0] K_RECV_REQ    = 3'd3;
  localparam logic [2:0] K_SEND_INV    = 3'd4;
  localparam logic [2:0] K_SEND_INVACK = 3'd5;
  localparam logic [2:0] K_RECV_INVACK = 3'd6;
  localparam logic [2:0] K_SEND_GNT    = 3'd7;

  // Node field value that turns kinds 1..6 into Store rules.
  localparam node_t STORE_NODE = 2'd3;

  // Power-on contents: everything idle/empty, memory and aux data at 1.
  function automatic german_state_t reset_state();
    german_state_t s;
    s          = '0;
    s.cur_cmd  = CMD_EMPTY;
    s.mem_data = data_t'(1);
    s.aux_data = data_t'(1);
    return s;
  endfunction

endpackage

// File: rtl/german_if.sv
// german_if: observation bundle exporting the model's registered state.
// The master side (the model) drives the state snapshot and a flag that is
// high once at least one rule edge has passed since reset.
interface german_if;
  import german_pkg::*;

  german_state_t state;
  logic          state_valid;

  modport master (output state, output state_valid);
  modport slave  (input  state, input  state_valid);
endinterface

// File: rtl/german_system.sv
// german_system: cycle-level German protocol, 3 caches + home directory.
// io_en_a selects at most one guarded rule per cycle ([4:2] kind, [1:0] node).
// Optional macro GERMAN_ASSERT_EN adds CtrlProp/DataProp immediate assertions.
module german_system
  import german_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] io_en_a,
  german_if.master         obs
);

  german_state_t state_q, state_d;
  logic          valid_q, valid_d;
  logic [2:0]    kind;
  node_t         node;

  assign kind = io_en_a[4:2];
  assign node = io_en_a[1:0];

  assign obs.state       = state_q;
  assign obs.state_valid = valid_q;

  // Next state: apply the selected rule if its guard holds, else hold.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b1;

    for (int i = 0; i < NUM_NODES; i++) begin
      if (node == NODE_W'(i)) begin
        case (kind)
          K_RECV_GNT: begin
            if (state_q.chan2[i].cmd == CMD_GNTS) begin
              state_d.cache[i].state = CACHE_S;
              state_d.cache[i].data  = state_q.chan2[i].data;
              state_d.chan2[i].cmd   = CMD_EMPTY;
              state_d.chan2[i].data  = '0;
            end else if (state_q.chan2[i].cmd == CMD_GNTE) begin
              state_d.cache[i].state = CACHE_E;
              state_d.cache[i].data  = state_q.chan2[i].data;
              state_d.chan2[i].cmd   = CMD_EMPTY;
              state_d.chan2[i].data  = '0;
            end
          end
          K_SEND_REQS: begin
            if (state_q.chan1[i].cmd == CMD_EMPTY &&
                state_q.cache[i].state == CACHE_I) begin
              state_d.chan1[i].cmd = CMD_REQS;
            end
          end
          K_SEND_REQE: begin
            if (state_q.chan1[i].cmd == CMD_EMPTY &&
                (state_q.cache[i].state == CACHE_I ||
                 state_q.cache[i].state == CACHE_S)) begin
              state_d.chan1[i].cmd = CMD_REQE;
            end
          end
          K_RECV_REQ: begin
            if (state_q.cur_cmd == CMD_EMPTY &&
                (state_q.chan1[i].cmd == CMD_REQS ||
                 state_q.chan1[i].cmd == CMD_REQE)) begin
              state_d.cur_cmd      = state_q.chan1[i].cmd;
              state_d.cur_ptr      = NODE_W'(i);
              state_d.chan1[i].cmd = CMD_EMPTY;
              // Every current sharer becomes a candidate for invalidation.
              state_d.inv_set      = state_q.shr_set;
            end
          end
          K_SEND_INV: begin
            if (state_q.chan2[i].cmd == CMD_EMPTY && state_q.inv_set[i] &&
                (state_q.cur_cmd == CMD_REQE ||
                 (state_q.cur_cmd == CMD_REQS && state_q.ex_gntd))) begin
              state_d.chan2[i].cmd = CMD_INV;
              state_d.inv_set[i]   = 1'b0;
            end
          end
          K_SEND_INVACK: begin
            if (state_q.chan2[i].cmd == CMD_INV &&
                state_q.chan3[i].cmd == CMD_EMPTY) begin
              state_d.chan2[i].cmd   = CMD_EMPTY;
              state_d.chan3[i].cmd   = CMD_INVACK;
              // Only an exclusive owner writes its (possibly dirty) data back.
              state_d.chan3[i].data  = (state_q.cache[i].state == CACHE_E) ?
                                       state_q.cache[i].data : '0;
              state_d.cache[i].state = CACHE_I;
              state_d.cache[i].data  = '0;
            end
          end
          K_RECV_INVACK: begin
            if (state_q.chan3[i].cmd == CMD_INVACK &&
                state_q.cur_cmd != CMD_EMPTY) begin
              state_d.chan3[i].cmd  = CMD_EMPTY;
              state_d.chan3[i].data = '0;
              state_d.shr_set[i]    = 1'b0;
              if (state_q.ex_gntd) begin
                state_d.ex_gntd  = 1'b0;
                state_d.mem_data = state_q.chan3[i].data;
              end
            end
          end
          K_SEND_GNT: begin
            if (state_q.cur_ptr == NODE_W'(i) &&
                state_q.chan2[i].cmd == CMD_EMPTY && !state_q.ex_gntd) begin
              if (state_q.cur_cmd == CMD_REQS) begin
                state_d.chan2[i].cmd  = CMD_GNTS;
                state_d.chan2[i].data = state_q.mem_data;
                state_d.shr_set[i]    = 1'b1;
                state_d.cur_cmd       = CMD_EMPTY;
              end else if (state_q.cur_cmd == CMD_REQE &&
                           state_q.shr_set == '0) begin
                state_d.chan2[i].cmd  = CMD_GNTE;
                state_d.chan2[i].data = state_q.mem_data;
                state_d.ex_gntd       = 1'b1;
                state_d.shr_set[i]    = 1'b1;
                state_d.cur_cmd       = CMD_EMPTY;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Store rules: node field 3, kinds 2i+1 (data 1) and 2i+2 (data 2).
    for (int i = 0; i < NUM_NODES; i++) begin
      if (node == STORE_NODE &&
          (kind == 3'(2 * i + 1) || kind == 3'(2 * i + 2)) &&
          state_q.cache[i].state == CACHE_E) begin
        state_d.cache[i].data = (kind == 3'(2 * i + 1)) ? data_t'(1) : data_t'(2);
        state_d.aux_data      = (kind == 3'(2 * i + 1)) ? data_t'(1) : data_t'(2);
      end
    end
  end

  // State register; reset takes effect immediately and overrides any rule.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= reset_state();
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

`ifdef GERMAN_ASSERT_EN
  logic ctrl_ok, data_ok;

  // Invariant evaluation: exclusivity and data consistency.
  always_comb begin
    int num_e;
    int num_s;
    num_e   = 0;
    num_s   = 0;
    data_ok = state_q.ex_gntd || (state_q.mem_data == state_q.aux_data);
    for (int i = 0; i < NUM_NODES; i++) begin
      if (state_q.cache[i].state == CACHE_E) num_e = num_e + 1;
      if (state_q.cache[i].state == CACHE_S) num_s = num_s + 1;
      if ((state_q.cache[i].state == CACHE_E || state_q.cache[i].state == CACHE_S) &&
          state_q.cache[i].data != state_q.aux_data) begin
        data_ok = 1'b0;
      end
    end
    ctrl_ok = (num_e <= 1) && !(num_e == 1 && num_s > 0);
  end

  // Check the invariants on every clock outside reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ctrl_prop: assert (ctrl_ok);
      data_prop: assert (data_ok);
    end
  end
`endif

endmodule

// File: tb/tb_german_system.sv
// tb_german_system: directed rule sequences with a scoreboard.
// Each step pushes the hand-derived state expected after its clock edge;
// an independent monitor pops and compares on the following falling edge.
module tb_german_system;
  import german_pkg::*;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic [4:0] io_en_a = 5'b11111;

  german_if obs_if ();

  german_system dut (
    .clock   (clock),
    .reset   (reset),
    .io_en_a (io_en_a),
    .obs     (obs_if)
  );

  always #5 clock = ~clock;

  german_state_t exp;
  german_state_t exp_q[$];
  string         name_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            pushes   = 0;
  int            pops     = 0;

  // Reset contents written out by hand: all zero except MemData/AuxData = 1.
  function automatic german_state_t reset_values();
    german_state_t s;
    s          = '0;
    s.mem_data = 2'd1;
    s.aux_data = 2'd1;
    return s;
  endfunction

  task automatic check(input string name, input german_state_t got,
                       input german_state_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got state=%h expected state=%h", name, got, want);
    end else begin
      $display("check %s ok state=%h", name, got);
    end
  endtask

  // Issue one rule; the expectation is queued once its edge has occurred.
  task automatic step(input string name, input logic [4:0] sel);
    @(negedge clock);
    io_en_a = sel;
    @(posedge clock);
    exp_q.push_back(exp);
    name_q.push_back(name);
    pushes++;
  endtask

  // Mid-cycle asynchronous reset held across two edges with a live rule.
  task automatic do_reset();
    @(negedge clock);
    io_en_a = 5'b11111;
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    io_en_a = 5'b00100;
    @(negedge clock);
    @(negedge clock);
    io_en_a = 5'b11111;
    #2 reset = 1'b0;
    exp = reset_values();
  endtask

  // Monitor: reset contents while in reset, else scoreboard comparisons.
  always @(negedge clock) begin
    if (reset) begin
      check("reset_hold", obs_if.state, reset_values());
    end else if (obs_if.state_valid && exp_q.size() > 0) begin
      pops++;
      check(name_q.pop_front(), obs_if.state, exp_q.pop_front());
    end
  end

  // Monitor: reset must clear state without waiting for a clock edge.
  always @(posedge reset) begin
    #1;
    check("reset_async", obs_if.state, reset_values());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pushes=%0d pops=%0d", pushes, pops);
    $fatal(1);
  end

  initial begin
    exp = reset_values();
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;

    // Grant-S path
    exp.chan1[0].cmd = CMD_REQS;
    step("send_reqs_n0", 5'b00100);
    exp.cur_cmd = CMD_REQS; exp.cur_ptr = 2'd0; exp.chan1[0].cmd = CMD_EMPTY;
    step("recv_req_n0", 5'b01100);
    exp.chan2[0] = '{cmd: CMD_GNTS, data: 2'd1}; exp.shr_set[0] = 1'b1;
    exp.cur_cmd = CMD_EMPTY;
    step("send_gnts_n0", 5'b11100);
    exp.cache[0] = '{state: CACHE_S, data: 2'd1};
    exp.chan2[0] = '{cmd: CMD_EMPTY, data: 2'd0};
    step("recv_gnts_n0", 5'b00000);
    step("store_on_s_blocked", 5'b00111);
    step("noop_11111", 5'b11111);
    step("reqs_on_s_blocked", 5'b00100);

    // Exclusive grant and Store, from a fresh reset
    do_reset();
    step("gnt_no_req_blocked", 5'b11100);
    exp.chan1[1].cmd = CMD_REQE;
    step("send_reqe_n1", 5'b01001);
    exp.cur_cmd = CMD_REQE; exp.cur_ptr = 2'd1; exp.chan1[1].cmd = CMD_EMPTY;
    step("recv_req_n1", 5'b01101);
    exp.chan2[1] = '{cmd: CMD_GNTE, data: 2'd1}; exp.ex_gntd = 1'b1;
    exp.shr_set[1] = 1'b1; exp.cur_cmd = CMD_EMPTY;
    step("send_gnte_n1", 5'b11101);
    exp.cache[1] = '{state: CACHE_E, data: 2'd1};
    exp.chan2[1] = '{cmd: CMD_EMPTY, data: 2'd0};
    step("recv_gnte_n1", 5'b00001);
    exp.cache[1].data = 2'd2; exp.aux_data = 2'd2;
    step("store_c1_d2", 5'b10011);
    step("store_on_i_blocked", 5'b00111);

    // Invalidation of the exclusive owner
    exp.chan1[0].cmd = CMD_REQE;
    step("send_reqe_n0", 5'b01000);
    exp.cur_cmd = CMD_REQE; exp.cur_ptr = 2'd0; exp.chan1[0].cmd = CMD_EMPTY;
    exp.inv_set = 3'b010;
    step("recv_reqe_n0", 5'b01100);
    step("gnt_blocked_exgntd", 5'b11100);
    exp.chan2[1].cmd = CMD_INV; exp.inv_set[1] = 1'b0;
    step("send_inv_n1", 5'b10001);
    exp.chan2[1].cmd = CMD_EMPTY; exp.chan3[1] = '{cmd: CMD_INVACK, data: 2'd2};
    exp.cache[1] = '{state: CACHE_I, data: 2'd0};
    step("send_invack_n1", 5'b10101);
    exp.chan3[1] = '{cmd: CMD_EMPTY, data: 2'd0}; exp.shr_set[1] = 1'b0;
    exp.ex_gntd = 1'b0; exp.mem_data = 2'd2;
    step("recv_invack_n1", 5'b11001);
    exp.chan2[0] = '{cmd: CMD_GNTE, data: 2'd2}; exp.ex_gntd = 1'b1;
    exp.shr_set[0] = 1'b1; exp.cur_cmd = CMD_EMPTY;
    step("send_gnte_n0", 5'b11100);
    exp.cache[0] = '{state: CACHE_E, data: 2'd2};
    exp.chan2[0] = '{cmd: CMD_EMPTY, data: 2'd0};
    step("recv_gnte_n0", 5'b00000);

    // Pending request in flight, then reset mid-run
    exp.chan1[1].cmd = CMD_REQS;
    step("send_reqs_n1", 5'b00101);
    exp.cur_cmd = CMD_REQS; exp.cur_ptr = 2'd1; exp.chan1[1].cmd = CMD_EMPTY;
    exp.inv_set = 3'b001;
    step("recv_reqs_n1", 5'b01101);
    do_reset();
    exp.chan1[0].cmd = CMD_REQS;
    step("post_reset_reqs_n0", 5'b00100);

    @(negedge clock);
    io_en_a = 5'b11111;
    repeat (3) @(negedge clock);

    checks++;
    if (pops != pushes || exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: popped %0d of %0d pushed, %0d left",
               pops, pushes, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
